// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: one power-of-two shift step per stage,
// a register after every stage, and a valid/ready handshake on both sides.
// Every stage advances together; a stalled output freezes the whole pipe.
module pipelined_barrel_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   IVALID,
    output logic                   IREADY,
    input  logic [DATA_WIDTH-1:0]  IDATA,
    input  logic [SHAMT_WIDTH-1:0] SHAMT,
    input  logic [2:0]             MODE,
    output logic                   OVALID,
    input  logic                   OREADY,
    output logic [DATA_WIDTH-1:0]  ODATA,
    output logic                   OZERO
);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // One fixed-distance shift of the selected kind; unknown modes pass data through.
    function automatic logic [DATA_WIDTH-1:0] f_shift(
        input logic [DATA_WIDTH-1:0] x,
        input logic [2:0]            m,
        input int                    s
    );
        logic [DATA_WIDTH-1:0] r;
        case (m)
            MODE_LSL: r = x << s;
            MODE_LSR: r = x >> s;
            // The sign bit never changes across stages, so the current MSB is the fill.
            MODE_ASR: r = DATA_WIDTH'($signed(x) >>> s);
            MODE_ROL: r = (x << s) | (x >> (DATA_WIDTH - s));
            MODE_ROR: r = (x >> s) | (x << (DATA_WIDTH - s));
            default:  r = x;
        endcase
        return r;
    endfunction

    // Pipeline enable: the output register is empty or being drained.
    logic w_adv;
    assign w_adv  = ~OVALID | OREADY;
    assign IREADY = w_adv & RSTN;

    // Stage registers. The last stage needs no mode/shamt: nothing follows it.
    logic                   r_valid [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0]  r_data  [SHAMT_WIDTH];
    logic [2:0]             r_mode  [SHAMT_WIDTH-1];
    logic [SHAMT_WIDTH-1:0] r_shamt [SHAMT_WIDTH-1];
    logic                   r_zero;

    // Stage inputs and the shifted data each stage will capture.
    logic                   w_in_valid [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0]  w_in_data  [SHAMT_WIDTH];
    logic [2:0]             w_in_mode  [SHAMT_WIDTH];
    logic [SHAMT_WIDTH-1:0] w_in_shamt [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0]  w_out_data [SHAMT_WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_stage
            localparam int STEP = 1 << gi;

            if (gi == 0) begin : g_src_port
                // A bubble enters stage 0 whenever nothing is accepted.
                assign w_in_valid[gi] = IVALID & IREADY;
                assign w_in_data[gi]  = IDATA;
                assign w_in_mode[gi]  = MODE;
                assign w_in_shamt[gi] = SHAMT;
            end else begin : g_src_prev
                assign w_in_valid[gi] = r_valid[gi-1];
                assign w_in_data[gi]  = r_data[gi-1];
                assign w_in_mode[gi]  = r_mode[gi-1];
                assign w_in_shamt[gi] = r_shamt[gi-1];
            end

            assign w_out_data[gi] = w_in_shamt[gi][gi]
                                  ? f_shift(w_in_data[gi], w_in_mode[gi], STEP)
                                  : w_in_data[gi];

            // Capture valid and data for this stage when the pipe advances.
            always_ff @(posedge CLK) begin
                if (!RSTN) begin
                    r_valid[gi] <= 1'b0;
                    r_data[gi]  <= '0;
                end else if (w_adv) begin
                    r_valid[gi] <= w_in_valid[gi];
                    r_data[gi]  <= w_out_data[gi];
                end
            end

            if (gi < SHAMT_WIDTH - 1) begin : g_ctrl
                // Carry mode and shift amount forward for the later stages.
                always_ff @(posedge CLK) begin
                    if (!RSTN) begin
                        r_mode[gi]  <= '0;
                        r_shamt[gi] <= '0;
                    end else if (w_adv) begin
                        r_mode[gi]  <= w_in_mode[gi];
                        r_shamt[gi] <= w_in_shamt[gi];
                    end
                end
            end else begin : g_zero
                // Zero flag is registered with the final data so both leave together.
                always_ff @(posedge CLK) begin
                    if (!RSTN) begin
                        r_zero <= 1'b0;
                    end else if (w_adv) begin
                        r_zero <= (w_out_data[gi] == '0);
                    end
                end
            end
        end
    endgenerate

    assign OVALID = r_valid[SHAMT_WIDTH-1];
    assign ODATA  = r_data[SHAMT_WIDTH-1];
    assign OZERO  = r_zero;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: three instances (W = 32, 8, 64) share one
// stimulus stream; each has its own scoreboard fed by an arithmetic model.
module tb_pipelined_barrel_shifter;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic        ivalid = 1'b0;
    logic        oready = 1'b1;
    logic [2:0]  mode   = 3'd0;
    logic [5:0]  shamt  = 6'd0;
    logic [63:0] idata  = 64'd0;

    logic        iready [3];
    logic        ovalid [3];
    logic        ozero  [3];
    logic [63:0] odata  [3];
    logic [31:0] od32;
    logic [7:0]  od8;
    logic [63:0] od64;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.DATA_WIDTH(32)) u_w32 (
        .CLK(clk), .RSTN(rstn), .IVALID(ivalid), .IREADY(iready[0]),
        .IDATA(idata[31:0]), .SHAMT(shamt[4:0]), .MODE(mode),
        .OVALID(ovalid[0]), .OREADY(oready), .ODATA(od32), .OZERO(ozero[0])
    );
    pipelined_barrel_shifter #(.DATA_WIDTH(8)) u_w8 (
        .CLK(clk), .RSTN(rstn), .IVALID(ivalid), .IREADY(iready[1]),
        .IDATA(idata[7:0]), .SHAMT(shamt[2:0]), .MODE(mode),
        .OVALID(ovalid[1]), .OREADY(oready), .ODATA(od8), .OZERO(ozero[1])
    );
    pipelined_barrel_shifter #(.DATA_WIDTH(64)) u_w64 (
        .CLK(clk), .RSTN(rstn), .IVALID(ivalid), .IREADY(iready[2]),
        .IDATA(idata), .SHAMT(shamt), .MODE(mode),
        .OVALID(ovalid[2]), .OREADY(oready), .ODATA(od64), .OZERO(ozero[2])
    );

    assign odata[0] = {32'd0, od32};
    assign odata[1] = {56'd0, od8};
    assign odata[2] = od64;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    logic [63:0] sb [3][512];
    int          wr_p [3] = '{0, 0, 0};
    int          rd_p [3] = '{0, 0, 0};
    bit          prev_stall [3] = '{0, 0, 0};
    logic [63:0] prev_data [3];
    logic        prev_zero [3];

    logic [63:0] got_data [64];
    logic        got_zero [64];
    int          got_n = 0;

    function automatic int width_of(int d);
        case (d)
            0:       return 32;
            1:       return 8;
            default: return 64;
        endcase
    endfunction

    // Reference: whole shift in one step with plain masked arithmetic.
    function automatic logic [63:0] ref_shift(logic [63:0] x_in, int m, int s_in, int w);
        logic [63:0] mask, x, r;
        int s;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x    = x_in & mask;
        s    = s_in & (w - 1);
        case (m)
            0: r = (x << s) & mask;
            1: r = x >> s;
            2: begin
                r = x >> s;
                if (x[w-1]) r = r | (mask & ~(mask >> s));
            end
            3: r = ((x << s) | (x >> (w - s))) & mask;
            4: r = ((x >> s) | (x << (w - s))) & mask;
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, check each DUT against its scoreboard.
    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 3; d++) begin
                int w;
                w = width_of(d);
                chk($sformatf("w%0d_iready", w), {63'd0, iready[d]},
                    {63'd0, rstn & (~ovalid[d] | oready)});
                if (prev_stall[d]) begin
                    chk($sformatf("w%0d_hold_valid", w), {63'd0, ovalid[d]}, 64'd1);
                    chk($sformatf("w%0d_hold_data", w), odata[d], prev_data[d]);
                    chk($sformatf("w%0d_hold_zero", w), {63'd0, ozero[d]}, {63'd0, prev_zero[d]});
                end
                if (wr_p[d] == rd_p[d]) begin
                    chk($sformatf("w%0d_spurious_valid", w), {63'd0, ovalid[d]}, 64'd0);
                end else if (ovalid[d] === 1'b1) begin
                    chk($sformatf("w%0d_data", w), odata[d], sb[d][rd_p[d] % 512]);
                    chk($sformatf("w%0d_zero", w), {63'd0, ozero[d]},
                        {63'd0, sb[d][rd_p[d] % 512] == 64'd0});
                end

                if (!rstn) begin
                    rd_p[d]       = wr_p[d];
                    prev_stall[d] = 1'b0;
                end else begin
                    if (ovalid[d] === 1'b1 && oready && wr_p[d] != rd_p[d]) begin
                        if (d == 0 && got_n < 64) begin
                            got_data[got_n] = odata[d];
                            got_zero[got_n] = ozero[d];
                            got_n++;
                        end
                        rd_p[d]++;
                    end
                    if (ivalid && iready[d] === 1'b1) begin
                        sb[d][wr_p[d] % 512] = ref_shift(idata, int'(mode), int'(shamt), w);
                        wr_p[d]++;
                    end
                    prev_stall[d] = (ovalid[d] === 1'b1) && !oready;
                    prev_data[d]  = odata[d];
                    prev_zero[d]  = ozero[d];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int k);
        ivalid = 1'b0;
        oready = 1'b1;
        repeat (k) step();
    endtask

    task automatic issue(logic [63:0] x, logic [2:0] m, logic [5:0] s);
        idata  = x;
        mode   = m;
        shamt  = s;
        ivalid = 1'b1;
        step();
        $display("issue data=%h mode=%0d shamt=%0d", x, m, s);
    endtask

    // Single beat into an empty pipe; count cycles until the W=32 result shows.
    task automatic latency(string name, logic [63:0] x, logic [2:0] m, logic [5:0] s);
        int n;
        issue(x, m, s);
        ivalid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ovalid[0] !== 1'b1 && n < 20);
        chk(name, 64'(n), 64'd5);
        #1;
    endtask

    initial begin
        // Reset held for three cycles with IVALID high.
        rstn   = 1'b0;
        ivalid = 1'b1;
        idata  = {$urandom, $urandom};
        step();
        armed = 1'b1;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            chk("reset_ovalid", {63'd0, ovalid[d]}, 64'd0);
            chk("reset_odata", odata[d], 64'd0);
            chk("reset_iready", {63'd0, iready[d]}, 64'd0);
        end
        rstn   = 1'b1;
        ivalid = 1'b0;
        step();
        chk("iready_after_reset", {63'd0, iready[0]}, 64'd1);
        drain(3);

        // Nominal latency, then all five modes back to back.
        latency("latency_first", 64'h8000_00F1, 3'd0, 6'd4);
        drain(8);
        for (int m = 0; m < 5; m++) issue(64'h8000_00F1, 3'(m), 6'd4);
        drain(10);

        // Boundary shift amounts.
        issue(64'hDEAD_BEEF, 3'd2, 6'd0);
        issue(64'h0000_0001, 3'd4, 6'd31);
        issue(64'h0000_0001, 3'd1, 6'd31);
        drain(10);

        // Backpressure while the pipe is full.
        for (int c = 0; c < 14; c++) begin
            oready = !(c >= 6 && c < 10);
            if (c == 8) chk("bp_iready", {63'd0, iready[0]}, 64'd0);
            issue({$urandom, $urandom}, 3'($urandom_range(0, 4)), 6'($urandom));
        end
        drain(12);

        // Reset mid-stream: in-flight beats must vanish.
        for (int i = 0; i < 3; i++) issue({$urandom, $urandom}, 3'($urandom_range(0, 4)), 6'($urandom));
        ivalid = 1'b0;
        step();
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        latency("latency_after_reset", 64'h0000_00F0, 3'd1, 6'd4);
        drain(10);

        // Pass-through modes ignore the shift amount.
        for (int i = 0; i < 6; i++) issue({$urandom, $urandom}, 3'(5 + i % 3), 6'($urandom));
        drain(10);

        // Random regression with random valid and ready.
        for (int i = 0; i < 10000; i++) begin
            ivalid = ($urandom_range(0, 9) < 7);
            oready = ($urandom_range(0, 3) != 0);
            mode   = 3'($urandom_range(0, 7));
            shamt  = 6'($urandom);
            idata  = {$urandom, $urandom};
            step();
        end
        drain(20);
        for (int d = 0; d < 3; d++)
            chk($sformatf("w%0d_drained", width_of(d)), 64'(wr_p[d] - rd_p[d]), 64'd0);

        // Literal expectations for the directed W=32 results.
        chk("model_asr", ref_shift(64'h8000_00F1, 2, 4, 32), 64'hF800_000F);
        chk("model_ror", ref_shift(64'h8000_00F1, 4, 4, 32), 64'h1800_000F);
        chk("log_count", {63'd0, got_n >= 9}, 64'd1);
        if (got_n >= 9) begin
            chk("lit_latency_lsl", got_data[0], 64'h0000_0F10);
            chk("lit_lsl", got_data[1], 64'h0000_0F10);
            chk("lit_lsr", got_data[2], 64'h0800_000F);
            chk("lit_asr", got_data[3], 64'hF800_000F);
            chk("lit_rol", got_data[4], 64'h0000_0F18);
            chk("lit_ror", got_data[5], 64'h1800_000F);
            chk("lit_shamt0_asr", got_data[6], 64'hDEAD_BEEF);
            chk("lit_ror31", got_data[7], 64'h0000_0002);
            chk("lit_lsr31", got_data[8], 64'h0000_0000);
            chk("lit_lsr31_zero", {63'd0, got_zero[8]}, 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
